// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Parametrised single-clock FIFO with fill count, almost-full /
//            almost-empty thresholds, synchronous flush, sticky overflow /
//            underflow flags and a selectable registered or
//            first-word-fall-through (FWFT) read port.
// Ports    : clk, rst_n (async, active-low)
//            flush                         - synchronous clear of contents
//            wr_en, wr_data                - write request / word
//            full, almost_full             - decodes of the fill count
//            rd_en, rd_data, rd_valid      - read request / word / valid
//            empty, almost_empty           - decodes of the fill count
//            count                         - current fill level
//            overflow, underflow, clr_err  - sticky error flags and clear
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         full,
    output logic                         almost_full,
    input  logic                         rd_en,
    output logic [DATA_WIDTH-1:0]        rd_data,
    output logic                         rd_valid,
    output logic                         empty,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         clr_err
);

    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam int c_ptr_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(DEPTH - 1);
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_af       = c_cnt_w'(AF_THRESH);
    localparam logic [c_cnt_w-1:0] c_ae       = c_cnt_w'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0] count_q,  count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic w_wr_acc;
    logic w_rd_acc;
    logic w_wr_err;
    logic w_rd_err;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [c_ptr_w-1:0] ptr_inc(input logic [c_ptr_w-1:0] p);
        return (p == c_ptr_last) ? '0 : p + 1'b1;
    endfunction

    // Status flags decode the registered count only.
    assign full         = (count_q == c_depth);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= c_af);
    assign almost_empty = (count_q <= c_ae);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // Flush masks both ports and any error event in its cycle.
    assign w_wr_acc = wr_en && !full  && !flush;
    assign w_rd_acc = rd_en && !empty && !flush;
    assign w_wr_err = wr_en &&  full  && !flush;
    assign w_rd_err = rd_en &&  empty && !flush;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_wr_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (w_rd_acc) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
        // A new error event wins over a coincident clear.
        overflow_d  = (overflow_q  && !clr_err) || w_wr_err;
        underflow_d = (underflow_q && !clr_err) || w_rd_err;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head of queue is always presented; rd_en only pops it.
            assign rd_data  = mem_q[rd_ptr_q];
            assign rd_valid = !empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
            logic                  rd_valid_q, rd_valid_d;

            always_comb begin
                rd_data_d  = rd_data_q;
                rd_valid_d = w_rd_acc;
                if (w_rd_acc) begin
                    rd_data_d = mem_q[rd_ptr_q];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data_q  <= '0;
                    rd_valid_q <= 1'b0;
                end else begin
                    rd_data_q  <= rd_data_d;
                    rd_valid_q <= rd_valid_d;
                end
            end

            assign rd_data  = rd_data_q;
            assign rd_valid = rd_valid_q;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Directed self-checking bench for sync_fifo_param. Two instances
//            (registered read and FWFT) share one stimulus stream; DEPTH=8,
//            AF_THRESH=6, AE_THRESH=1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int DW = 8;
    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush, wr_en, rd_en, clr_err;
    logic [DW-1:0] wr_data;

    logic          full, almost_full, rd_valid, empty, almost_empty, overflow, underflow;
    logic [DW-1:0] rd_data;
    logic [CW-1:0] count;

    logic          f_full, f_almost_full, f_rd_valid, f_empty, f_almost_empty;
    logic          f_overflow, f_underflow;
    logic [DW-1:0] f_rd_data;
    logic [CW-1:0] f_count;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(6), .AE_THRESH(1), .FWFT(0)
    ) u_reg (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .almost_full(almost_full), .rd_en(rd_en), .rd_data(rd_data),
        .rd_valid(rd_valid), .empty(empty), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    sync_fifo_param #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(6), .AE_THRESH(1), .FWFT(1)
    ) u_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
        .full(f_full), .almost_full(f_almost_full), .rd_en(rd_en), .rd_data(f_rd_data),
        .rd_valid(f_rd_valid), .empty(f_empty), .almost_empty(f_almost_empty), .count(f_count),
        .overflow(f_overflow), .underflow(f_underflow), .clr_err(clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = '0;
        repeat (2) tick();

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_af", almost_full, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_udf", underflow, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_f_rd_valid", f_rd_valid, 0);
        rst_n = 1'b1;
        tick();

        // Fill 0x01..0x08 back to back, checking thresholds on the way
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; wr_data = DW'(i);
            tick();
            chk("fill_count", count, i);
            chk("fill_full", full, (i == 8));
            chk("fill_ae", almost_empty, (i <= 1));
            chk("fill_af", almost_full, (i >= 6));
            chk("fill_empty", empty, 0);
        end
        wr_en = 1'b0;

        // Write while full is dropped and flagged
        push(8'hAA);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 8);

        // Drain: data order and one-cycle read latency
        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1;
            tick();
            chk("drain_valid", rd_valid, 1);
            chk("drain_data", rd_data, i);
            chk("drain_count", count, 8 - i);
        end
        rd_en = 1'b0;
        chk("drain_empty", empty, 1);
        tick();
        chk("idle_valid", rd_valid, 0);
        chk("idle_hold", rd_data, 8'h08);

        // Read while empty
        pop();
        chk("udf_set", underflow, 1);
        chk("udf_valid", rd_valid, 0);
        chk("udf_count", count, 0);

        // Clear both flags
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_ovf", overflow, 0);
        chk("clr_udf", underflow, 0);

        // Clear coincident with an overflow event keeps the flag set
        for (int i = 0; i < 8; i++) push(DW'(8'h10 + i));
        chk("refill_full", full, 1);
        clr_err = 1'b1; wr_en = 1'b1; wr_data = 8'hBB;
        tick();
        clr_err = 1'b0; wr_en = 1'b0;
        chk("clr_vs_ovf", overflow, 1);

        // Simultaneous read+write at full: read taken, write dropped
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h99;
        tick();
        wr_en = 1'b0;
        chk("fullrw_count", count, 7);
        chk("fullrw_ovf", overflow, 1);
        chk("fullrw_data", rd_data, 8'h10);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("fullrw_drain", rd_data, 8'h10 + i);
        end
        rd_en = 1'b0;
        chk("fullrw_empty", empty, 1);
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_ovf2", overflow, 0);

        // Steady state at count=4, pointers wrap more than twice
        for (int i = 0; i < 4; i++) push(DW'(8'h20 + i));
        for (int k = 0; k < 20; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = DW'(8'h24 + k);
            tick();
            chk("rw_count", count, 4);
            chk("rw_data", rd_data, 8'h20 + k);
        end
        wr_en = 1'b0;
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("rw_tail", rd_data, 8'h34 + j);
        end
        rd_en = 1'b0;
        chk("rw_empty", empty, 1);

        // Flush at count=5 overrides coincident write and read
        for (int i = 0; i < 5; i++) push(DW'(8'h40 + i));
        chk("pre_flush_count", count, 5);
        flush = 1'b1; wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'hEE;
        tick();
        flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_valid", rd_valid, 0);
        chk("flush_hold", rd_data, 8'h37);
        chk("flush_ovf", overflow, 0);
        chk("flush_udf", underflow, 0);
        flush = 1'b1; rd_en = 1'b1;
        tick();
        flush = 1'b0; rd_en = 1'b0;
        chk("flush_empty_rd", underflow, 0);
        push(8'h50);
        pop();
        chk("post_flush_data", rd_data, 8'h50);
        chk("post_flush_count", count, 0);

        // FWFT read port
        chk("fwft_idle_valid", f_rd_valid, 0);
        push(8'h5C);
        chk("fwft_valid", f_rd_valid, 1);
        chk("fwft_empty", f_empty, 0);
        chk("fwft_data", f_rd_data, 8'h5C);
        chk("reg_no_valid", rd_valid, 0);
        push(8'h6D);
        chk("fwft_head_hold", f_rd_data, 8'h5C);
        pop();
        chk("fwft_next", f_rd_data, 8'h6D);
        chk("fwft_valid2", f_rd_valid, 1);
        chk("reg_vs_fwft", rd_data, 8'h5C);
        pop();
        chk("fwft_drained", f_empty, 1);
        chk("fwft_novalid", f_rd_valid, 0);

        // Asynchronous reset in the middle of a burst
        pop();
        chk("pre_rst_udf", underflow, 1);
        push(8'h71);
        push(8'h72);
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h73;
        tick();
        chk("pre_rst_valid", rd_valid, 1);
        chk("pre_rst_data", rd_data, 8'h71);
        chk("pre_rst_count", count, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_count", count, 0);
        chk("arst_empty", empty, 1);
        chk("arst_ae", almost_empty, 1);
        chk("arst_udf", underflow, 0);
        chk("arst_valid", rd_valid, 0);
        chk("arst_data", rd_data, 0);
        chk("arst_f_valid", f_rd_valid, 0);
        chk("arst_f_count", f_count, 0);
        wr_en = 1'b0; rd_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_count", count, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
